// File: rtl/coax_rx_stream.sv
// Drains the coax receiver FIFO into a valid/ready stream, holding one word back
// to tag the last word of each frame and turning receiver faults into error beats.
module coax_rx_stream #(
  parameter int unsigned MAX_WORDS      = 1024,
  parameter logic [9:0]  ERROR_TOO_LONG = 10'h3FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  rx_data,
  input  logic        rx_empty,
  input  logic        rx_error,
  input  logic        rx_active,
  output logic        read_strobe,
  output logic        rx_reset,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [9:0]  m_data,
  output logic        m_last,
  output logic        m_error,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERR_OUT,
    ERR_WAIT
  } state_t;

  state_t      state;
  logic [9:0]  h_data;
  logic        h_valid;
  logic        too_long;
  logic        err_loaded;

  logic        accept;
  logic        in_frame;
  logic        can_capture;
  logic        can_flush;
  logic        at_limit;

  always_comb begin
    accept   = m_valid & m_ready;
    in_frame = (state == IDLE) || (state == RUN);
    at_limit = 32'(word_count) >= MAX_WORDS;
    // A pending last beat blocks the next frame so its word_count clear cannot collide with a capture.
    can_capture = in_frame & ~rx_error & ~rx_empty & ~read_strobe &
                  (~h_valid | ~m_valid) & ~(m_valid & m_last);
    can_flush   = in_frame & ~rx_error & h_valid & ~m_valid & ~rx_active &
                  rx_empty & ~read_strobe;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      h_data      <= '0;
      h_valid     <= 1'b0;
      too_long    <= 1'b0;
      err_loaded  <= 1'b0;
      read_strobe <= 1'b0;
      rx_reset    <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      m_error     <= 1'b0;
      word_count  <= '0;
    end else begin
      read_strobe <= 1'b0;
      rx_reset    <= 1'b0;
      if (accept) begin
        m_valid <= 1'b0;
        if (m_last && !m_error) word_count <= '0;
      end
      case (state)
        IDLE, RUN: begin
          if (rx_error) begin
            h_valid  <= 1'b0;
            too_long <= 1'b0;
            state    <= ERR_OUT;
          end else if (can_capture) begin
            if (at_limit) begin
              h_valid  <= 1'b0;
              too_long <= 1'b1;
              state    <= ERR_OUT;
            end else begin
              read_strobe <= 1'b1;
              h_data      <= rx_data;
              h_valid     <= 1'b1;
              word_count  <= word_count + 16'd1;
              state       <= RUN;
              if (h_valid) begin
                m_valid <= 1'b1;
                m_data  <= h_data;
                m_last  <= 1'b0;
                m_error <= 1'b0;
              end
            end
          end else if (can_flush) begin
            m_valid <= 1'b1;
            m_data  <= h_data;
            m_last  <= 1'b1;
            m_error <= 1'b0;
            h_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        ERR_OUT: begin
          if (!m_valid && !err_loaded) begin
            m_valid    <= 1'b1;
            m_data     <= too_long ? ERROR_TOO_LONG : rx_data;
            m_last     <= 1'b1;
            m_error    <= 1'b1;
            err_loaded <= 1'b1;
          end else if (err_loaded && accept) begin
            rx_reset   <= 1'b1;
            word_count <= '0;
            err_loaded <= 1'b0;
            state      <= ERR_WAIT;
          end
        end
        ERR_WAIT: begin
          if (!rx_error && rx_empty && !rx_reset) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coax_rx_stream.sv
// Randomized frame-level bench: a FIFO/receiver model feeds the DUT and a
// transaction model predicts every accepted beat, pop count and reset pulse.
module tb_coax_rx_stream;

  localparam int MAXW = 8;
  localparam logic [9:0] TOO_LONG = 10'h3FF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  rx_data = '0;
  logic        rx_empty = 1'b1;
  logic        rx_error = 1'b0;
  logic        rx_active = 1'b0;
  logic        read_strobe;
  logic        rx_reset;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [9:0]  m_data;
  logic        m_last;
  logic        m_error;
  logic [15:0] word_count;

  coax_rx_stream #(.MAX_WORDS(MAXW), .ERROR_TOO_LONG(TOO_LONG)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_error(rx_error), .rx_active(rx_active), .read_strobe(read_strobe),
    .rx_reset(rx_reset), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_error(m_error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] d;
    logic       last;
    logic       err;
    int         wc;
  } beat_t;

  beat_t      exp_q[$];
  logic [9:0] fifo[$];
  logic [9:0] wr_q[$];
  logic [9:0] fw[16];
  logic [9:0] err_code = '0;
  bit         err_req = 0;
  bit         hold_active = 0;
  int         ready_mode = 0;
  int         rs_cnt = 0;
  int         rst_cnt = 0;
  int         exp_pops = 0;
  int         exp_resets = 0;
  int         n_total = 0;
  int         n_pass = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic void push_beat(input logic [9:0] d, input logic last, input logic err, input int wc);
    beat_t b;
    b.d = d; b.last = last; b.err = err; b.wc = wc;
    exp_q.push_back(b);
  endfunction

  // kind 0: frame of n words (aborts if n > MAXW); kind 1: receiver error after n words.
  function automatic void model(input int kind, input int n, input logic [9:0] code);
    exp_resets = 0;
    if (kind == 1) begin
      for (int i = 0; i < n - 1; i++) push_beat(fw[i], 1'b0, 1'b0, 0);
      push_beat(code, 1'b1, 1'b1, 0);
      exp_pops = n;
      exp_resets = 1;
    end else if (n > MAXW) begin
      for (int i = 0; i < MAXW - 1; i++) push_beat(fw[i], 1'b0, 1'b0, 0);
      push_beat(TOO_LONG, 1'b1, 1'b1, 0);
      exp_pops = MAXW;
      exp_resets = 1;
    end else begin
      for (int i = 0; i < n; i++) push_beat(fw[i], i == n - 1, 1'b0, n);
      exp_pops = n;
    end
  endfunction

  // Receiver/FIFO environment plus the per-cycle output monitor.
  initial begin : env
    bit pop_seen = 0, rstp_seen = 0, prev_stall = 0, prev_rs = 0, prev_rsr = 0, wrote;
    logic [9:0] pd;
    logic pl, pe;
    beat_t e;
    pd = '0; pl = 0; pe = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pop_seen = 0; rstp_seen = 0; prev_stall = 0; prev_rs = 0; prev_rsr = 0;
      end else begin
        if (prev_stall)
          chk(m_valid && m_data == pd && m_last == pl && m_error == pe, "hold_stable",
              {m_valid, m_error, m_last, m_data}, {1'b1, pe, pl, pd});
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) chk(0, "extra_beat", {m_error, m_last, m_data}, 0);
          else begin
            e = exp_q.pop_front();
            chk(m_data == e.d && m_last == e.last && m_error == e.err, "beat",
                {m_error, m_last, m_data}, {e.err, e.last, e.d});
            if (e.last && !e.err) chk(int'(word_count) == e.wc, "wc_at_last", word_count, e.wc);
          end
        end
        if (m_valid && m_error) chk(m_last, "err_has_last", m_last, 1);
        if (read_strobe) begin
          chk(!prev_rs, "pop_spacing", prev_rs, 0);
          rs_cnt++;
        end
        if (rx_reset) begin
          chk(!prev_rsr, "rx_reset_width", prev_rsr, 0);
          rst_cnt++;
        end
        prev_stall = m_valid && !m_ready;
        pd = m_data; pl = m_last; pe = m_error;
        prev_rs = read_strobe; prev_rsr = rx_reset;
        pop_seen = read_strobe; rstp_seen = rx_reset;
      end
      @(posedge clk);
      #1;
      if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
      if (rstp_seen) begin
        fifo.delete(); wr_q.delete(); err_req = 0;
      end
      pop_seen = 0; rstp_seen = 0;
      wrote = 0;
      if (wr_q.size() > 0) begin
        fifo.push_back(wr_q.pop_front());
        wrote = 1;
      end
      rx_active = hold_active || wrote || (wr_q.size() > 0);
      rx_error  = err_req;
      rx_empty  = (fifo.size() == 0);
      rx_data   = err_req ? err_code : (fifo.size() > 0 ? fifo[0] : 10'h000);
      m_ready   = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete(); fifo.delete(); wr_q.delete();
    err_req = 0; hold_active = 0; ready_mode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int kind, input int n, input logic [9:0] code, input int rmode, input int stall);
    bit ok;
    rs_cnt = 0; rst_cnt = 0;
    model(kind, n, code);
    hold_active = (kind == 1);
    ready_mode = (stall > 0) ? 0 : rmode;
    for (int i = 0; i < n; i++) wr_q.push_back(fw[i]);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk(rs_cnt == 2, "bp_pops", rs_cnt, 2);
      chk(m_valid && m_data == fw[0], "bp_hold", {m_valid, m_data}, {1'b1, fw[0]});
      ready_mode = rmode;
    end
    if (kind == 1) begin
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
        @(negedge clk);
        ok = (rs_cnt == n);
      end
      if (!ok) chk(0, "timeout_pops", rs_cnt, n);
      repeat (3) @(posedge clk);
      err_code = code;
      err_req = 1;
    end
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = exp_q.size() == 0 && fifo.size() == 0 && wr_q.size() == 0 && !m_valid && !err_req;
    end
    if (!ok) begin
      chk(0, "timeout_frame", exp_q.size(), 0);
      do_reset();
      return;
    end
    repeat (6) @(negedge clk);
    hold_active = 0;
    chk(word_count == 16'd0, "wc_cleared", word_count, 0);
    chk(rs_cnt == exp_pops, "pop_count", rs_cnt, exp_pops);
    chk(rst_cnt == exp_resets, "rx_reset_count", rst_cnt, exp_resets);
  endtask

  initial begin : main
    int kind, n, rm;
    logic [9:0] code;
    #1;
    chk(!m_valid && !read_strobe && !rx_reset && !m_last && !m_error && m_data == 0 && word_count == 0,
        "reset_state", {m_valid, read_strobe, rx_reset, m_last, m_error}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Pin the model with hand-derived expectations.
    fw[0] = 10'd1; fw[1] = 10'd2; fw[2] = 10'd3;
    model(0, 3, '0);
    chk(exp_q.size() == 3 && exp_pops == 3, "pin_len3", exp_q.size(), 3);
    chk(exp_q[0].d == 10'd1 && !exp_q[0].last && exp_q[2].d == 10'd3 && exp_q[2].last && exp_q[2].wc == 3,
        "pin_beats3", exp_q[2].d, 3);
    exp_q.delete();
    for (int i = 0; i < 10; i++) fw[i] = 10'(i + 1);
    model(0, 10, '0);
    chk(exp_q.size() == MAXW && exp_q[MAXW-1].d == TOO_LONG && exp_q[MAXW-1].err &&
        exp_q[MAXW-2].d == 10'd7 && exp_pops == MAXW, "pin_too_long", exp_q.size(), MAXW);
    exp_q.delete();

    fw[0] = 10'd1; fw[1] = 10'd2; fw[2] = 10'd3;
    run(0, 3, '0, 1, 0);
    fw[0] = 10'h155;
    run(0, 1, '0, 1, 0);
    for (int i = 0; i < 8; i++) fw[i] = 10'(i + 1);
    run(0, 8, '0, 1, 40);
    fw[0] = 10'd1; fw[1] = 10'd2;
    run(1, 2, 10'h002, 1, 0);
    for (int i = 0; i < 9; i++) fw[i] = 10'(i + 1);
    run(0, 9, '0, 2, 0);

    // Asynchronous reset with both hold and output registers occupied.
    ready_mode = 0; hold_active = 1;
    for (int i = 0; i < 6; i++) wr_q.push_back(10'(i + 20));
    repeat (30) @(negedge clk);
    chk(m_valid, "pre_reset_loaded", m_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk(!m_valid && !read_strobe && word_count == 0 && !rx_reset, "async_reset",
        {m_valid, read_strobe, rx_reset, word_count}, 0);
    exp_q.delete(); fifo.delete(); wr_q.delete(); hold_active = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fw[0] = 10'h0AA; fw[1] = 10'h0BB;
    run(0, 2, '0, 1, 0);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 9);
      rm = $urandom_range(1, 2);
      code = 10'($urandom_range(0, 1022));
      if (kind < 5) begin kind = 0; n = $urandom_range(1, MAXW); end
      else if (kind < 7) begin kind = 0; n = $urandom_range(MAXW + 1, 12); end
      else begin kind = 1; n = $urandom_range(1, 5); end
      for (int i = 0; i < 16; i++) fw[i] = 10'($urandom_range(0, 1022));
      run(kind, n, code, rm, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/coax_rx_stream.md
Name: coax_rx_stream

Overview:
- Downstream consumer of the buffered coax receiver.
- Drains the receiver FIFO through its show-ahead read interface (data/empty/error/read_strobe) and presents received 10-bit words as a valid/ready stream with frame delimiting (last) and error tagging.
- Holds one word back so it can mark the final word of each frame once the receiver goes idle.
- Recovers from receiver errors by emitting an error beat and pulsing a receiver reset.

Parameters:
MAX_WORDS, 1024, maximum words per frame; the word that would exceed it aborts the frame.
ERROR_TOO_LONG, 10'h3FF, error code placed on m_data when a frame exceeds MAX_WORDS.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
rx_data  input  10  FIFO head word (show-ahead); when rx_error=1 this is the receiver error code
rx_empty  input  1  receiver FIFO empty
rx_error  input  1  receiver error flag, sticky until rx_reset
rx_active  input  1  receiver is mid-frame; falls no earlier than the cycle after the last word is written
read_strobe  output  1  one-cycle pop of FIFO head
rx_reset  output  1  one-cycle reset pulse to the receiver after an error
m_valid  output  1  stream beat valid
m_ready  input  1  stream consumer ready
m_data  output  10  word, or error code when m_error=1
m_last  output  1  final beat of frame
m_error  output  1  beat is an error beat (always with m_last=1)
word_count  output  16  words captured in current frame

Behaviour:
- Reset: all outputs 0, hold register empty (h_valid=0), state IDLE. Takes effect immediately (async); any in-flight frame is discarded.
- Storage: hold register H (h_valid) and output register O (m_valid, m_data, m_last, m_error). Output beat transfers when m_valid & m_ready; m_* stay stable while m_valid & !m_ready.
- State IDLE/RUN: capture is allowed when rx_error=0, rx_empty=0, no pop pending, and (h_valid=0 or m_valid=0).
- Capture cycle:
  - Assert registered read_strobe for exactly one cycle.
  - Capture rx_data.
  - If h_valid, move H to O with m_last=0.
  - Load H with the captured word; word_count += 1.
  - The following cycle is a mandatory WAIT (pop pending), so there is at most one pop per 2 cycles.
- Flush: when h_valid=1, m_valid=0, rx_active=0, rx_empty=0->1 settled (rx_empty=1) and no pop pending:
  - O=H, m_last=1; h_valid=0.
  - word_count cleared when the last beat is accepted.
- Length abort: a capture that would make word_count > MAX_WORDS does not pop. Instead it enters ERR with code ERROR_TOO_LONG.
- Error (rx_error=1 sampled in any non-error state, checked before capture):
  - Discard H; any word already in O completes normally.
  - Enter ERR_OUT.
- ERR_OUT:
  - When m_valid=0, load O with m_data=rx_data (or ERROR_TOO_LONG), m_error=1, m_last=1.
  - Once the beat is accepted, pulse rx_reset for 1 cycle.
  - Clear word_count; go to ERR_WAIT.
- ERR_WAIT: no pops; return to IDLE when rx_error=0 and rx_empty=1.
- Simultaneous events:
  - rx_error and a capture-eligible cycle: error wins, no read_strobe.
  - m_ready and flush eligibility in the same cycle: the O slot frees this cycle and the flush loads next cycle. One load into O per cycle.
- Latency: first word reaches m_valid only once a second word is captured or the frame ends (flush). Minimum is 4 cycles from rx_empty falling for a single-word frame.
- Backpressure: with O and H full, no further pops; words remain in the upstream FIFO.

Test Plan:
- 3-word frame (1, 2, 3), m_ready=1 -> 3 read_strobe pulses; beats 1/last=0, 2/last=0, 3/last=1; word_count reaches 3 then 0 after last beat.
- Single-word frame 10'h155 -> one beat with m_last=1, m_error=0; exactly 1 read_strobe.
- 8 words queued, m_ready=0 for 40 cycles -> exactly 2 read_strobe pulses; m_data=1 held stable. Release m_ready -> 8 beats in order, last only on word 8.
- rx_error=1 with rx_data=10'h002 after 2 words are captured (word 1 in O) -> beat 1/last=0, then error beat 10'h002 with m_error=1, m_last=1; word 2 dropped; rx_reset pulses 1 cycle; IDLE after rx_error falls.
- MAX_WORDS=4, 5-word frame -> beats 1, 2, 3 (last=0), then an ERROR_TOO_LONG beat with m_error=1; only 4 read_strobe pulses; rx_reset pulses.
- Reset asserted mid-frame with H and O loaded -> m_valid, read_strobe, word_count, and rx_reset are 0 immediately; the next frame streams cleanly.
